// File: rtl/exec_sequencer_pkg.sv
// exec_seq_pkg: class codes, FSM state encoding and default unit latencies for exec_sequencer.
package exec_seq_pkg;
  typedef enum logic [1:0] {CLS_ALU = 2'b00, CLS_MUL = 2'b01, CLS_DIV = 2'b10, CLS_FPU = 2'b11} cls_t;
  typedef enum logic [1:0] {ST_IDLE = 2'b00, ST_RUN = 2'b01, ST_DONE = 2'b10} state_t;
  localparam int ALU_LAT_D = 1;
  localparam int MUL_LAT_D = 2;
  localparam int DIV_LAT_D = 33;
  localparam int FPU_LAT_D = 4;
  function automatic int max4(input int a, input int b, input int c, input int d);
    int m;
    m = a > b ? a : b;
    m = m > c ? m : c;
    return m > d ? m : d;
  endfunction
endpackage

// File: rtl/exec_sequencer_if.sv
// exec_sequencer_if: issue, unit-control and writeback handshake bundle; slave is the sequencer side.
interface exec_sequencer_if;
  logic        issue_valid;
  logic        issue_ready;
  logic [1:0]  issue_class;
  logic [2:0]  issue_funct3;
  logic [4:0]  issue_funct5;
  logic        flush;
  logic [1:0]  unit_sel;
  logic [2:0]  unit_funct3;
  logic [4:0]  unit_funct5;
  logic        unit_start;
  logic [31:0] unit_result;
  logic        result_valid;
  logic        result_ready;
  logic [31:0] result_data;
  logic        busy;
  logic        stall;
  modport master (
    output issue_valid, issue_class, issue_funct3, issue_funct5, flush, unit_result, result_ready,
    input  issue_ready, unit_sel, unit_funct3, unit_funct5, unit_start, result_valid, result_data, busy, stall
  );
  modport slave (
    input  issue_valid, issue_class, issue_funct3, issue_funct5, flush, unit_result, result_ready,
    output issue_ready, unit_sel, unit_funct3, unit_funct5, unit_start, result_valid, result_data, busy, stall
  );
endinterface

// File: rtl/exec_lat_counter.sv
// exec_lat_counter: loadable down-counter that saturates at zero and flags when it gets there.
module exec_lat_counter #(
  parameter int W = 6
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic         zero
);
  logic [W-1:0] cnt;
  always_ff @(posedge clk)
    if (rst) cnt <= '0;
    else cnt <= load ? load_val : (dec && cnt != '0) ? cnt - 1'b1 : cnt;
  assign zero = cnt == '0;
endmodule

// File: rtl/exec_sequencer.sv
// exec_sequencer: single-op issue/completion controller for ALU/MUL/DIV/FPU units.
// Optional EXEC_SEQ_PERF_EN adds perf_ops/perf_stall counters.
module exec_sequencer
  import exec_seq_pkg::*;
#(
  parameter int ALU_LAT = ALU_LAT_D,
  parameter int MUL_LAT = MUL_LAT_D,
  parameter int DIV_LAT = DIV_LAT_D,
  parameter int FPU_LAT = FPU_LAT_D
) (
  input  logic clk,
  input  logic rst,
  exec_sequencer_if.slave bus
`ifdef EXEC_SEQ_PERF_EN
  ,
  output logic [31:0] perf_ops,
  output logic [31:0] perf_stall
`endif
);
  localparam int MAX_LAT = max4(ALU_LAT, MUL_LAT, DIV_LAT, FPU_LAT);
  localparam int CW = MAX_LAT > 1 ? $clog2(MAX_LAT) : 1;
  state_t state;
  logic [1:0] sel;
  logic [2:0] f3;
  logic [4:0] f5;
  logic start, zero, accept;
  logic [31:0] data;
  logic [CW-1:0] lat_m1;
  assign bus.issue_ready = ~bus.flush & (state == ST_IDLE | (state == ST_DONE & bus.result_ready));
  assign accept = bus.issue_valid & bus.issue_ready;
  assign bus.stall = bus.issue_valid & ~bus.issue_ready;
  assign lat_m1 = bus.issue_class == CLS_ALU ? CW'(ALU_LAT - 1) :
                  bus.issue_class == CLS_MUL ? CW'(MUL_LAT - 1) :
                  bus.issue_class == CLS_DIV ? CW'(DIV_LAT - 1) : CW'(FPU_LAT - 1);
  exec_lat_counter #(.W(CW)) u_cnt (
    .clk(clk), .rst(rst), .load(accept), .load_val(lat_m1), .dec(state == ST_RUN), .zero(zero)
  );
  // Accept is tested before retire so a DONE op can hand over to a new op on the same edge.
  always_ff @(posedge clk)
    if (rst) begin
      state <= ST_IDLE;
      sel <= '0;
      f3 <= '0;
      f5 <= '0;
      start <= 1'b0;
      data <= '0;
    end else begin
      start <= accept;
      if (bus.flush) state <= ST_IDLE;
      else if (accept) begin
        state <= ST_RUN;
        sel <= bus.issue_class;
        f3 <= bus.issue_funct3;
        f5 <= bus.issue_funct5;
      end else if (state == ST_RUN && zero) begin
        state <= ST_DONE;
        data <= bus.unit_result;
      end else if (state == ST_DONE && bus.result_ready) state <= ST_IDLE;
    end
  assign bus.unit_sel = sel;
  assign bus.unit_funct3 = f3;
  assign bus.unit_funct5 = f5;
  assign bus.unit_start = start;
  assign bus.result_data = data;
  assign bus.result_valid = state == ST_DONE;
  assign bus.busy = state != ST_IDLE;
`ifdef EXEC_SEQ_PERF_EN
  always_ff @(posedge clk)
    if (rst) begin
      perf_ops <= '0;
      perf_stall <= '0;
    end else begin
      perf_ops <= perf_ops + {31'd0, accept};
      perf_stall <= perf_stall + {31'd0, bus.stall};
    end
`endif
endmodule

// File: tb/tb_exec_sequencer.sv
// tb_exec_sequencer: directed scenarios plus random traffic against a transaction-timing reference model.
module tb_exec_sequencer;
  import exec_seq_pkg::*;
  logic clk = 1'b0;
  logic rst;
  int checks = 0;
  int failures = 0;
  exec_sequencer_if bus ();
`ifdef EXEC_SEQ_PERF_EN
  logic [31:0] perf_ops, perf_stall;
  exec_sequencer dut (.clk(clk), .rst(rst), .bus(bus), .perf_ops(perf_ops), .perf_stall(perf_stall));
`else
  exec_sequencer dut (.clk(clk), .rst(rst), .bus(bus));
`endif
  always #5 clk = ~clk;

  // model: the in-flight op is known only by its accept cycle and latency
  int cyc = 0;
  bit chk_en = 0;
  bit m_have;
  int m_acc, m_lat;
  logic [1:0] m_cls;
  logic [2:0] m_f3;
  logic [4:0] m_f5;
  logic [31:0] m_data;
  logic [31:0] m_ops, m_stl;
  logic s_ready, s_valid, s_busy, s_start, s_stall;
  logic [31:0] s_data;

  function automatic int lat_of(input logic [1:0] c);
    return c == 2'd0 ? 1 : c == 2'd1 ? 2 : c == 2'd2 ? 33 : 4;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s cycle=%0d got=%h exp=%h", tag, cyc, got, exp);
    end
  endtask

  task automatic step(input logic iv, input logic [1:0] cl, input logic [2:0] f3, input logic [4:0] f5,
                      input logic rr, input logic fl, input logic rs, input logic [31:0] ur);
    bit v_e, st_e, rdy_e, acc_e, stl_e;
    @(negedge clk);
    bus.issue_valid = iv; bus.issue_class = cl; bus.issue_funct3 = f3; bus.issue_funct5 = f5;
    bus.result_ready = rr; bus.flush = fl; rst = rs; bus.unit_result = ur;
    #1;
    v_e = m_have && cyc > m_acc + m_lat;
    st_e = m_have && cyc == m_acc + 1;
    rdy_e = !fl && (!m_have || (v_e && rr));
    acc_e = iv && rdy_e;
    stl_e = iv && !rdy_e;
    s_ready = bus.issue_ready; s_valid = bus.result_valid; s_busy = bus.busy;
    s_start = bus.unit_start; s_stall = bus.stall; s_data = bus.result_data;
    if (chk_en) begin
      chk("issue_ready", {31'd0, s_ready}, {31'd0, rdy_e});
      chk("stall", {31'd0, s_stall}, {31'd0, stl_e});
      chk("busy", {31'd0, s_busy}, {31'd0, m_have});
      chk("result_valid", {31'd0, s_valid}, {31'd0, v_e});
      chk("unit_start", {31'd0, s_start}, {31'd0, st_e});
      chk("unit_sel", {30'd0, bus.unit_sel}, {30'd0, m_cls});
      chk("unit_funct3", {29'd0, bus.unit_funct3}, {29'd0, m_f3});
      chk("unit_funct5", {27'd0, bus.unit_funct5}, {27'd0, m_f5});
      chk("result_data", s_data, m_data);
`ifdef EXEC_SEQ_PERF_EN
      chk("perf_ops", perf_ops, m_ops);
      chk("perf_stall", perf_stall, m_stl);
`endif
    end
    @(posedge clk);
    if (rs) begin
      m_have = 0; m_cls = '0; m_f3 = '0; m_f5 = '0; m_data = '0; m_ops = '0; m_stl = '0;
    end else begin
      m_ops += {31'd0, acc_e};
      m_stl += {31'd0, stl_e};
      if (fl) m_have = 0;
      else begin
        if (m_have && cyc == m_acc + m_lat) m_data = ur;
        if (v_e && rr) m_have = 0;
        if (acc_e) begin
          m_have = 1; m_acc = cyc; m_lat = lat_of(cl); m_cls = cl; m_f3 = f3; m_f5 = f5;
        end
      end
    end
    cyc++;
  endtask

  task automatic idle(input logic rr);
    step(1'b0, 2'd0, 3'd0, 5'd0, rr, 1'b0, 1'b0, $urandom);
  endtask

  initial begin
    int run;
    logic [31:0] held;
    m_have = 0;
    bus.issue_valid = 0; bus.issue_class = 0; bus.issue_funct3 = 0; bus.issue_funct5 = 0;
    bus.result_ready = 0; bus.flush = 0; bus.unit_result = 0; rst = 1;
    step(0, 0, 0, 0, 0, 0, 1, 0);
    step(0, 0, 0, 0, 0, 0, 1, 0);
    chk_en = 1;
    step(0, 0, 0, 0, 0, 0, 1, 0);
    chk("rst_busy", {31'd0, s_busy}, 32'd0);
    chk("rst_data", s_data, 32'd0);
    // ALU: valid two cycles after accept, data from the single RUN cycle
    step(1, CLS_ALU, 3'd5, 5'd9, 1, 0, 0, 32'h1111_1111);
    step(0, 0, 0, 0, 1, 0, 0, 32'hCAFE_F00D);
    chk("alu_start", {31'd0, s_start}, 32'd1);
    idle(1);
    chk("alu_valid", {31'd0, s_valid}, 32'd1);
    chk("alu_data", s_data, 32'hCAFE_F00D);
    // DIV: 33 RUN cycles, decode stalled throughout
    step(1, CLS_DIV, 3'd4, 5'd1, 0, 0, 0, $urandom);
    run = 0;
    for (int i = 0; i < 40 && !s_valid; i++) begin
      step(1, CLS_ALU, 3'd1, 5'd2, 0, 0, 0, $urandom);
      if (s_busy && !s_valid) run++;
    end
    chk("div_run_cycles", run, 32'd33);
    chk("div_valid", {31'd0, s_valid}, 32'd1);
    idle(1);
    // MUL held in DONE, then back-to-back handover
    step(1, CLS_MUL, 3'd0, 5'd3, 0, 0, 0, $urandom);
    for (int i = 0; i < 8 && !s_valid; i++) idle(0);
    held = s_data;
    for (int i = 0; i < 5; i++) begin
      idle(0);
      chk("done_hold", s_data, held);
    end
    step(1, CLS_MUL, 3'd7, 5'd31, 1, 0, 0, $urandom);
    chk("b2b_ready", {31'd0, s_ready}, 32'd1);
    idle(1);
    chk("b2b_start", {31'd0, s_start}, 32'd1);
    idle(1);
    idle(1);
    idle(1);
    // FPU flushed in its third RUN cycle
    step(1, CLS_FPU, 3'd2, 5'd7, 1, 0, 0, $urandom);
    idle(1);
    idle(1);
    step(0, 0, 0, 0, 1, 1, 0, $urandom);
    for (int i = 0; i < 5; i++) begin
      idle(1);
      chk("flush_no_valid", {31'd0, s_valid | s_busy}, 32'd0);
    end
    step(1, CLS_ALU, 3'd3, 5'd4, 1, 0, 0, $urandom);
    idle(1);
    idle(1);
    chk("post_flush_valid", {31'd0, s_valid}, 32'd1);
    idle(1);
    // reset with flush mid-DIV
    step(1, CLS_DIV, 3'd6, 5'd17, 1, 0, 0, $urandom);
    for (int i = 0; i < 5; i++) idle(1);
    step(1, CLS_FPU, 0, 0, 1, 1, 1, $urandom);
    idle(1);
    chk("rst_mid_busy", {31'd0, s_busy | s_valid | s_start}, 32'd0);
    chk("rst_mid_sel", {30'd0, bus.unit_sel}, 32'd0);
    chk("rst_mid_data", s_data, 32'd0);
`ifdef EXEC_SEQ_PERF_EN
    chk("rst_perf_ops", perf_ops, 32'd0);
    chk("rst_perf_stall", perf_stall, 32'd0);
    for (int i = 0; i < 3; i++) begin
      step(1, CLS_ALU, 0, 0, 1, 0, 0, $urandom);
      idle(1);
      idle(1);
    end
    step(1, CLS_DIV, 0, 0, 0, 0, 0, $urandom);
    for (int i = 0; i < 10; i++) step(1, CLS_ALU, 0, 0, 0, 0, 0, $urandom);
    idle(0);
    chk("perf_ops_4", perf_ops, 32'd4);
    chk("perf_stall_10", perf_stall, 32'd10);
`endif
    // random traffic
    for (int i = 0; i < 3000; i++)
      step($urandom_range(0, 9) < 6, 2'($urandom), 3'($urandom), 5'($urandom),
           $urandom_range(0, 9) < 7, $urandom_range(0, 99) < 3, $urandom_range(0, 199) < 1, $urandom);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
